// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR handshake: captures a request one cycle
// after mem_EN rises, waits LATENCY cycles, performs the access and holds MFC until mem_EN drops.
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_EN,
    input  logic              mem_RW,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              MFC,
    output logic              busy,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam logic [3:0] LAT_CNT  = 4'(LATENCY);
    localparam bit         ZERO_LAT = (LATENCY == 0);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    logic              w_access;
    logic              w_acc_rw;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_wdata;

    // With zero latency the access happens at the capture edge, so it uses the live inputs.
    assign w_access    = mem_EN && ((r_state == ST_SETUP && ZERO_LAT) ||
                                    (r_state == ST_WAIT  && r_cnt == 4'd1));
    assign w_acc_rw    = (r_state == ST_SETUP) ? mem_RW : r_rw;
    assign w_acc_addr  = (r_state == ST_SETUP) ? addr   : r_addr;
    assign w_acc_wdata = (r_state == ST_SETUP) ? wdata  : r_wdata;

    assign busy        = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (w_access && !w_acc_rw) begin
            r_mem[w_acc_addr] <= w_acc_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            MFC     <= 1'b0;
            rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mem_EN) r_state <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (!mem_EN) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rw    <= mem_RW;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        if (ZERO_LAT) begin
                            r_state <= ST_ACK;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= LAT_CNT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!mem_EN) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= ST_ACK;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    if (!mem_EN) begin
                        r_state <= ST_IDLE;
                        MFC     <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_access) begin
                MFC <= 1'b1;
                if (w_acc_rw) rdata <= r_mem[w_acc_addr];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=3 and a LATENCY=0 instance driven by directed
// and random requests, checked against an array memory model and a latency formula.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en  [2];
    logic        rw  [2];
    logic [7:0]  a   [2];
    logic [15:0] wd  [2];
    logic [15:0] rd  [2];
    logic        mfc [2];
    logic        bsy [2];
    logic [1:0]  st  [2];

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [15:0] mem_m  [2][256];
    bit          mem_v  [2][256];
    logic [15:0] exp_rd [2];
    logic [15:0] exp_q  [$];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .mem_EN(en[0]), .mem_RW(rw[0]), .addr(a[0]), .wdata(wd[0]),
        .rdata(rd[0]), .MFC(mfc[0]), .busy(bsy[0]), .o_dbg_state(st[0])
    );

    mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst), .mem_EN(en[1]), .mem_RW(rw[1]), .addr(a[1]), .wdata(wd[1]),
        .rdata(rd[1]), .MFC(mfc[1]), .busy(bsy[1]), .o_dbg_state(st[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 3 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble(input int d, input bit writes);
        rw[d] = writes ? 1'b0 : 1'($urandom_range(0, 1));
        a[d]  = ($urandom_range(0, 1) == 1) ? 8'h12 : 8'($urandom_range(0, 63));
        wd[d] = 16'($urandom);
    endtask

    // Starts and ends on a falling edge; mem_EN is low on return.
    task automatic do_req(input int d, input bit rw_cap, input bit rw_setup, input logic [7:0] addr,
                          input logic [15:0] wdata, input int hold, input bit scr_w);
        int          edges;
        logic [15:0] exp;
        en[d] = 1'b1; rw[d] = rw_setup; a[d] = addr; wd[d] = wdata;
        @(negedge clk);
        check("setup_busy", 32'(bsy[d]), 32'd1);
        check("setup_mfc", 32'(mfc[d]), 32'd0);
        rw[d] = rw_cap;
        exp_q.push_back(rw_cap ? mem_m[d][addr] : exp_rd[d]);
        if (!rw_cap) begin
            mem_m[d][addr] = wdata;
            mem_v[d][addr] = 1'b1;
        end
        @(negedge clk);
        edges = 2;
        scramble(d, 1'b0);
        while (!mfc[d] && edges < 40) begin
            @(negedge clk);
            edges++;
            scramble(d, 1'b0);
        end
        check("latency_edges", 32'(edges), 32'(2 + lat(d)));
        exp = exp_q.pop_front();
        check(rw_cap ? "read_data" : "write_rdata_held", 32'(rd[d]), 32'(exp));
        exp_rd[d] = exp;
        for (int i = 0; i < hold; i++) begin
            scramble(d, scr_w);
            @(negedge clk);
            check("hold_mfc", 32'(mfc[d]), 32'd1);
            check("hold_rdata", 32'(rd[d]), 32'(exp_rd[d]));
        end
        en[d] = 1'b0;
        @(negedge clk);
        check("drop_mfc", 32'(mfc[d]), 32'd0);
        check("drop_busy", 32'(bsy[d]), 32'd0);
    endtask

    // Holds mem_EN for k edges, then drops it before the access edge.
    task automatic do_abort(input int d, input logic [7:0] addr, input logic [15:0] wdata, input int k);
        en[d] = 1'b1; rw[d] = 1'b0; a[d] = addr; wd[d] = wdata;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check("abort_mfc", 32'(mfc[d]), 32'd0);
        end
        en[d] = 1'b0;
        @(negedge clk);
        check("abort_mfc_end", 32'(mfc[d]), 32'd0);
        check("abort_busy", 32'(bsy[d]), 32'd0);
        check("abort_rdata", 32'(rd[d]), 32'(exp_rd[d]));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         op;
        logic [7:0] ra;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0; rw[d] = 1'b0; a[d] = 8'h00; wd[d] = 16'h0000; exp_rd[d] = 16'h0000;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_mfc", 32'(mfc[d]), 32'd0);
            check("reset_busy", 32'(bsy[d]), 32'd0);
            check("reset_rdata", 32'(rd[d]), 32'd0);
            check("reset_state", 32'(st[d]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Write then read on the LATENCY=3 instance
        do_req(0, 1'b0, 1'b0, 8'h12, 16'hBEEF, 0, 1'b0);
        do_req(0, 1'b1, 1'b1, 8'h12, 16'h0000, 1, 1'b0);
        // mem_RW low during setup, high at capture: must be a read
        do_req(0, 1'b1, 1'b0, 8'h12, 16'h1111, 0, 1'b0);
        do_req(0, 1'b0, 1'b0, 8'h20, 16'h0F0F, 0, 1'b0);
        do_abort(0, 8'h20, 16'h1234, 3);
        do_req(0, 1'b1, 1'b1, 8'h20, 16'h0000, 0, 1'b0);
        // Long hold with writes scrambled on the bus: no extra access
        do_req(0, 1'b1, 1'b1, 8'h12, 16'h0000, 10, 1'b1);
        do_req(0, 1'b1, 1'b1, 8'h12, 16'h0000, 0, 1'b0);

        // Reset while a write to 0x05 is waiting
        do_req(0, 1'b0, 1'b0, 8'h05, 16'h5A5A, 0, 1'b0);
        do_req(0, 1'b1, 1'b1, 8'h12, 16'h0000, 0, 1'b0);
        en[0] = 1'b1; rw[0] = 1'b0; a[0] = 8'h05; wd[0] = 16'hDEAD;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mfc", 32'(mfc[0]), 32'd0);
        check("rst_busy", 32'(bsy[0]), 32'd0);
        check("rst_rdata", 32'(rd[0]), 32'd0);
        exp_rd[0] = 16'h0000;
        exp_rd[1] = 16'h0000;
        en[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_req(0, 1'b1, 1'b1, 8'h05, 16'h0000, 0, 1'b0);

        // LATENCY=0 instance: preload, then back-to-back reads
        do_req(1, 1'b0, 1'b0, 8'h00, 16'h00A5, 0, 1'b0);
        do_req(1, 1'b0, 1'b0, 8'h01, 16'h005A, 0, 1'b0);
        do_req(1, 1'b1, 1'b1, 8'h00, 16'h0000, 0, 1'b0);
        do_req(1, 1'b1, 1'b1, 8'h01, 16'h0000, 2, 1'b1);
        do_abort(1, 8'h01, 16'hFFFF, 1);
        do_req(1, 1'b1, 1'b0, 8'h01, 16'h0000, 0, 1'b0);

        // Random traffic on both instances
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 24; i++) begin
                op = $urandom_range(0, 9);
                ra = 8'($urandom_range(0, 63));
                if (op == 0)
                    do_abort(d, ra, 16'($urandom), $urandom_range(1, lat(d) + 1));
                else if (op < 6 && mem_v[d][ra])
                    do_req(d, 1'b1, 1'($urandom_range(0, 1)), ra, 16'($urandom), $urandom_range(0, 3), 1'b0);
                else
                    do_req(d, 1'b0, 1'($urandom_range(0, 1)), ra, 16'($urandom), $urandom_range(0, 3), 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
